mac_accum: RTL and testbench

Sequential multiply-accumulate stage built around the team's 4x4 unsigned array multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair. The registered pair feeds the combinational multiplier, and the 8-bit products of one dot product are summed into a wide accumulator. Each finished dot product is presented with status flags on a valid/ready output port toward the downstream consumer.

---
 rtl/mac_pkg.sv | 13 +
 rtl/mac_accum_if.sv | 33 +++
 rtl/mac_accum_array_mult.sv | 18 +
 rtl/mac_accum.sv | 147 ++++++++++++++
 tb/tb_mac_accum.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate datapath.
package mac_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      MAC_IDLE  = 2'd0,
      MAC_ACCUM = 2'd1,
      MAC_DONE  = 2'd2
   } mac_state_e;

endpackage

// File: rtl/mac_accum_if.sv
// Operand stream in, dot-product result out; master is the upstream/downstream side.
interface mac_accum_if
   import mac_pkg::*;
#(
   parameter int ACC_W   = 16,
   parameter int MAX_LEN = 16
) ();

   localparam int BEAT_W = $clog2(MAX_LEN + 1);

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_a;
   logic [OP_W-1:0]   in_b;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic              out_ovf;
   logic              out_trunc;
   logic [BEAT_W-1:0] out_beats;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf, out_trunc, out_beats
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_ovf, out_trunc, out_beats
   );

endinterface

// File: rtl/mac_accum_array_mult.sv
// 4x4 unsigned array multiplier: rows of gated partial products summed combinationally.
module array_mult
   import mac_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] p
);

   // Partial-product rows accumulated row by row.
   always_comb begin
      p = '0;
      for (int i = 0; i < OP_W; i++) begin
         p = p + ((PROD_W'(a) << i) & {PROD_W{b[i]}});
      end
   end

endmodule

// File: rtl/mac_accum.sv
// Two-stage multiply-accumulate: registered operand pair, then an accumulator FSM
// that releases each dot product with overflow/truncation status.
module mac_accum
   import mac_pkg::*;
#(
   parameter int ACC_W   = 16,
   parameter int MAX_LEN = 16
) (
   input logic        clk,
   input logic        rst_n,
   mac_accum_if.slave bus
);

   localparam int                BEAT_W    = $clog2(MAX_LEN + 1);
   localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_LEN);

   logic              stall_s;
   logic [OP_W-1:0]   a_r;
   logic [OP_W-1:0]   b_r;
   logic              v1_r;
   logic              last1_r;
   logic [PROD_W-1:0] prod_s;
   logic [ACC_W-1:0]  prod_ext_s;
   logic [ACC_W:0]    sum_s;
   logic [BEAT_W-1:0] beats_inc_s;
   logic              start_s;

   mac_state_e        state_r;
   logic [ACC_W-1:0]  acc_r;
   logic [BEAT_W-1:0] beats_r;
   logic              ovf_r;
   logic              out_valid_r;
   logic [ACC_W-1:0]  out_acc_r;
   logic              out_ovf_r;
   logic              out_trunc_r;
   logic [BEAT_W-1:0] out_beats_r;

   assign stall_s      = out_valid_r & ~bus.out_ready;
   assign bus.in_ready = ~stall_s;

   // Stage 1: operand register, frozen while the result port is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         v1_r    <= 1'b0;
         last1_r <= 1'b0;
      end else if (!stall_s) begin
         a_r     <= bus.in_a;
         b_r     <= bus.in_b;
         v1_r    <= bus.in_valid;
         last1_r <= bus.in_last;
      end
   end

   array_mult u_mult (
      .a (a_r),
      .b (b_r),
      .p (prod_s)
   );

   assign prod_ext_s  = ACC_W'(prod_s);
   assign sum_s       = {1'b0, acc_r} + {1'b0, prod_ext_s};
   assign beats_inc_s = beats_r + BEAT_W'(1);
   // A first beat is taken from IDLE, or from DONE in the release cycle (no bubble).
   assign start_s     = v1_r & ((state_r == MAC_IDLE) |
                                ((state_r == MAC_DONE) & bus.out_ready));

   // Stage 2: accumulator FSM with registered result fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= MAC_IDLE;
         acc_r       <= '0;
         beats_r     <= '0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_acc_r   <= '0;
         out_ovf_r   <= 1'b0;
         out_trunc_r <= 1'b0;
         out_beats_r <= '0;
      end else begin
         case (state_r)
            MAC_IDLE: begin
               state_r <= MAC_IDLE;
            end
            MAC_ACCUM: begin
               if (v1_r) begin
                  acc_r   <= sum_s[ACC_W-1:0];
                  beats_r <= beats_inc_s;
                  ovf_r   <= ovf_r | sum_s[ACC_W];
                  if (last1_r || (beats_inc_s == MAX_BEATS)) begin
                     state_r     <= MAC_DONE;
                     out_valid_r <= 1'b1;
                     out_acc_r   <= sum_s[ACC_W-1:0];
                     out_beats_r <= beats_inc_s;
                     out_ovf_r   <= ovf_r | sum_s[ACC_W];
                     out_trunc_r <= ~last1_r;
                  end else begin
                     state_r <= MAC_ACCUM;
                  end
               end else begin
                  state_r <= MAC_ACCUM;
               end
            end
            MAC_DONE: begin
               if (bus.out_ready) begin
                  state_r     <= MAC_IDLE;
                  out_valid_r <= 1'b0;
                  acc_r       <= '0;
                  beats_r     <= '0;
                  ovf_r       <= 1'b0;
               end else begin
                  state_r <= MAC_DONE;
               end
            end
            default: begin
               state_r <= MAC_IDLE;
            end
         endcase

         // Later assignments override the case above when a new dot product opens.
         if (start_s) begin
            acc_r   <= prod_ext_s;
            beats_r <= BEAT_W'(1);
            ovf_r   <= 1'b0;
            if (last1_r) begin
               state_r     <= MAC_DONE;
               out_valid_r <= 1'b1;
               out_acc_r   <= prod_ext_s;
               out_beats_r <= BEAT_W'(1);
               out_ovf_r   <= 1'b0;
               out_trunc_r <= 1'b0;
            end else begin
               state_r     <= MAC_ACCUM;
               out_valid_r <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_acc   = out_acc_r;
   assign bus.out_ovf   = out_ovf_r;
   assign bus.out_trunc = out_trunc_r;
   assign bus.out_beats = out_beats_r;

endmodule

// File: tb/tb_mac_accum.sv
// Scoreboard bench: two mac_accum instances (16/16 and 8/4) with directed dot products.
module tb_mac_accum;

   typedef struct {
      int acc;
      int ovf;
      int trunc;
      int beats;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0;
   exp_t e1;

   mac_accum_if #(.ACC_W(16), .MAX_LEN(16)) if0 ();
   mac_accum_if #(.ACC_W(8),  .MAX_LEN(4))  if1 ();

   mac_accum #(.ACC_W(16), .MAX_LEN(16)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   mac_accum #(.ACC_W(8), .MAX_LEN(4)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int acc, input int ovf, input int trunc, input int beats);
      exp_t e;
      e.acc   = acc;
      e.ovf   = ovf;
      e.trunc = trunc;
      e.beats = beats;
      return e;
   endfunction

   // Caller sits just after a rising edge; returns just after the accepting edge.
   task automatic send(input int idx, input int a, input int b, input bit last);
      bit rdy;
      bit done;
      done = 1'b0;
      if (idx == 0) begin
         if0.in_valid = 1'b1; if0.in_a = 4'(a); if0.in_b = 4'(b); if0.in_last = last;
      end else begin
         if1.in_valid = 1'b1; if1.in_a = 4'(a); if1.in_b = 4'(b); if1.in_last = last;
      end
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         rdy = (idx == 0) ? if0.in_ready : if1.in_ready;
         @(posedge clk);
         #1;
         if (rdy) done = 1'b1;
      end
      if (!done) chk("send_timeout", 0, 1);
      if0.in_valid = 1'b0; if0.in_last = 1'b0;
      if1.in_valid = 1'b0; if1.in_last = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor for instance 0: every released result is checked against the queue head.
   always @(negedge clk) begin
      if (rst_n && if0.out_valid && if0.out_ready) begin
         if (q0.size() == 0) begin
            chk("unexpected_result0", int'(if0.out_acc), -1);
         end else begin
            e0 = q0.pop_front();
            chk("acc0",   int'(if0.out_acc),   e0.acc);
            chk("ovf0",   int'(if0.out_ovf),   e0.ovf);
            chk("trunc0", int'(if0.out_trunc), e0.trunc);
            chk("beats0", int'(if0.out_beats), e0.beats);
         end
      end
   end

   // Monitor for instance 1.
   always @(negedge clk) begin
      if (rst_n && if1.out_valid && if1.out_ready) begin
         if (q1.size() == 0) begin
            chk("unexpected_result1", int'(if1.out_acc), -1);
         end else begin
            e1 = q1.pop_front();
            chk("acc1",   int'(if1.out_acc),   e1.acc);
            chk("ovf1",   int'(if1.out_ovf),   e1.ovf);
            chk("trunc1", int'(if1.out_trunc), e1.trunc);
            chk("beats1", int'(if1.out_beats), e1.beats);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      if0.in_valid = 1'b0; if0.in_a = 4'd0; if0.in_b = 4'd0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.in_a = 4'd0; if1.in_b = 4'd0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid0", int'(if0.out_valid), 0);
      chk("rst_acc0",   int'(if0.out_acc),   0);
      chk("rst_ovf0",   int'(if0.out_ovf),   0);
      chk("rst_trunc0", int'(if0.out_trunc), 0);
      chk("rst_beats0", int'(if0.out_beats), 0);
      chk("rst_ready0", int'(if0.in_ready),  1);
      chk("rst_ready1", int'(if1.in_ready),  1);
      @(posedge clk);
      #1;

      // Three-beat dot product and its latency.
      q0.push_back(mk(451, 0, 0, 3));
      send(0, 15, 15, 1'b0);
      send(0, 15, 15, 1'b0);
      send(0, 1, 1, 1'b1);
      @(negedge clk);
      chk("lat_not_yet", int'(if0.out_valid), 0);
      @(negedge clk);
      chk("lat_valid", int'(if0.out_valid), 1);
      cycles(2);

      // Backpressure: 9 held, queued (2,2,last) follows after release.
      if0.out_ready = 1'b0;
      q0.push_back(mk(9, 0, 0, 1));
      q0.push_back(mk(4, 0, 0, 1));
      send(0, 3, 3, 1'b1);
      send(0, 2, 2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_in_ready", int'(if0.in_ready),  0);
         chk("stall_valid",    int'(if0.out_valid), 1);
         chk("stall_acc",      int'(if0.out_acc),   9);
      end
      @(posedge clk);
      #1 if0.out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", int'(if0.in_ready), 1);
      cycles(4);

      // Back-to-back single-beat dot products.
      q0.push_back(mk(1, 0, 0, 1));
      q0.push_back(mk(4, 0, 0, 1));
      q0.push_back(mk(9, 0, 0, 1));
      send(0, 1, 1, 1'b1);
      send(0, 2, 2, 1'b1);
      send(0, 3, 3, 1'b1);
      @(negedge clk);
      chk("b2b_valid_a", int'(if0.out_valid), 1);
      @(negedge clk);
      chk("b2b_valid_b", int'(if0.out_valid), 1);
      @(negedge clk);
      chk("b2b_valid_end", int'(if0.out_valid), 0);
      @(posedge clk);
      #1;

      // MAX_LEN truncation, then the leftover beat closes with (0,9,last).
      q1.push_back(mk(24, 0, 1, 4));
      q1.push_back(mk(6, 0, 0, 2));
      for (int k = 0; k < 5; k++) send(1, 2, 3, 1'b0);
      send(1, 0, 9, 1'b1);
      cycles(4);

      // 8-bit accumulator wrap: 450 mod 256 = 194 with overflow.
      q1.push_back(mk(194, 1, 0, 2));
      send(1, 15, 15, 1'b0);
      send(1, 15, 15, 1'b1);
      cycles(4);

      // Reset in the middle of an open dot product.
      send(0, 4, 4, 1'b0);
      send(0, 4, 4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid0", int'(if0.out_valid), 0);
      chk("mid_rst_acc0",   int'(if0.out_acc),   0);
      chk("mid_rst_beats0", int'(if0.out_beats), 0);
      chk("mid_rst_acc1",   int'(if1.out_acc),   0);
      chk("mid_rst_ovf1",   int'(if1.out_ovf),   0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready0", int'(if0.in_ready), 1);
      q0.push_back(mk(25, 0, 0, 1));
      send(0, 5, 5, 1'b1);
      cycles(6);

      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
